ahbl_sram_slave_if: RTL and testbench

AHB-Lite slave front-end that sits directly upstream of the SRAM control interface in the AHB LSRAM core. It decodes AHB-Lite address and data phases, captures address, size and direction, and issues single-cycle requests to the SRAM controller. It inserts wait states until the controller acknowledges and read data is valid. Illegal accesses and acknowledge timeouts return a two-cycle AHB ERROR response.

---
 rtl/ahbl_sram_slave_if.sv | 219 +++++++++++++++++++++
 tb/tb_ahbl_sram_slave_if.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_sram_slave_if
// Purpose  : AHB-Lite slave front-end for the LSRAM controller. It decodes
//            the AHB-Lite address phase and checks size and alignment. It
//            captures the address, size and direction of each transfer and
//            issues a one-cycle request to the SRAM controller. Wait states
//            are inserted until the controller acknowledges and read data is
//            valid. Illegal accesses and acknowledge timeouts are answered
//            with a two-cycle AHB ERROR response.
//
// Parameters:
//   MEM_AWIDTH  - width of the byte address handed to the SRAM controller
//   ACK_TIMEOUT - maximum cycles spent waiting for an acknowledge (1..255)
//   SYNC_RESET  - 1: HRESETN acts synchronously, 0: asynchronous
//
// Ports:
//   HCLK, HRESETN      - clock (rising edge), active-low reset
//   HSEL .. HREADYIN   - AHB-Lite slave inputs (HBURST is ignored)
//   HREADYOUT, HRESP   - AHB-Lite response (registered)
//   HRDATA             - read data, straight from sramahb_rdata
//   ahbsram_*          - request side towards the SRAM controller
//   sramahb_ack/rdata  - controller acknowledge and read data
//   BUSY               - controller busy, holds the request off
//
// Revision : 1.0 - initial release
// ============================================================================
module ahbl_sram_slave_if #(
   parameter int MEM_AWIDTH  = 19,
   parameter int ACK_TIMEOUT = 15,
   parameter bit SYNC_RESET  = 1'b0
) (
   input  logic                  HCLK,
   input  logic                  HRESETN,
   // AHB-Lite slave port
   input  logic                  HSEL,
   input  logic [31:0]           HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [31:0]           HWDATA,
   input  logic                  HREADYIN,
   output logic                  HREADYOUT,
   output logic [1:0]            HRESP,
   output logic [31:0]           HRDATA,
   // SRAM controller request side
   output logic                  ahbsram_req,
   output logic                  ahbsram_write,
   output logic [2:0]            ahbsram_size,
   output logic [MEM_AWIDTH-1:0] ahbsram_addr,
   output logic [31:0]           ahbsram_wdata,
   // SRAM controller response side
   input  logic                  sramahb_ack,
   input  logic [31:0]           sramahb_rdata,
   input  logic                  BUSY
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQ      = 3'd1,
      S_WAIT_ACK = 3'd2,
      S_DONE     = 3'd3,
      S_ERR1     = 3'd4,
      S_ERR2     = 3'd5
   } state_t;

   localparam logic [1:0] c_resp_okay   = 2'b00;
   localparam logic [1:0] c_resp_error  = 2'b01;
   localparam logic [8:0] c_ack_timeout = 9'(ACK_TIMEOUT);

   state_t                r_state;
   logic                  r_hreadyout;
   logic [1:0]            r_hresp;
   logic [7:0]            r_ack_cnt;
   logic                  r_write;
   logic [2:0]            r_size;
   logic [MEM_AWIDTH-1:0] r_addr;

   logic                  w_valid;
   logic                  w_legal;
   logic                  w_timeout;
   logic                  w_arst_n;
   logic                  w_srst;

   // ------------------------------------------------------------------------
   // Reset style selection. Only one of the two paths is ever live; the other
   // is tied to its inactive level so the register block below stays single.
   // ------------------------------------------------------------------------
   generate
      if (SYNC_RESET) begin : g_sync_reset
         assign w_arst_n = 1'b1;
         assign w_srst   = ~HRESETN;
      end else begin : g_async_reset
         assign w_arst_n = HRESETN;
         assign w_srst   = 1'b0;
      end
   endgenerate

   // Address phase qualification: HTRANS[1] covers NONSEQ and SEQ.
   assign w_valid = HSEL & HREADYIN & HTRANS[1];

   // Size / alignment legality of the current address phase.
   always_comb begin
      w_legal = 1'b0;
      case (HSIZE)
         3'b000:  w_legal = 1'b1;
         3'b001:  w_legal = ~HADDR[0];
         3'b010:  w_legal = (HADDR[1:0] == 2'b00);
         default: w_legal = 1'b0;
      endcase
   end

   // The counter holds the number of completed WAIT_ACK cycles; the current
   // cycle is the last allowed one when the count is about to reach the limit.
   assign w_timeout = (({1'b0, r_ack_cnt} + 9'd1) >= c_ack_timeout);

   // ------------------------------------------------------------------------
   // Transfer state machine. HREADYOUT/HRESP are registered together with the
   // next state so they change cleanly on the clock edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge HCLK or negedge w_arst_n) begin
      if (!w_arst_n) begin
         r_state     <= S_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= c_resp_okay;
         r_ack_cnt   <= 8'd0;
         r_write     <= 1'b0;
         r_size      <= 3'd0;
         r_addr      <= '0;
      end else if (w_srst) begin
         r_state     <= S_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= c_resp_okay;
         r_ack_cnt   <= 8'd0;
         r_write     <= 1'b0;
         r_size      <= 3'd0;
         r_addr      <= '0;
      end else begin
         case (r_state)
            // States that present HREADYOUT=1 are the only ones that can
            // accept a new address phase.
            S_IDLE, S_DONE, S_ERR2: begin
               if (w_valid && w_legal) begin
                  r_state     <= S_REQ;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= c_resp_okay;
                  r_addr      <= HADDR[MEM_AWIDTH-1:0];
                  r_size      <= HSIZE;
                  r_write     <= HWRITE;
               end else if (w_valid) begin
                  r_state     <= S_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= c_resp_error;
               end else begin
                  r_state     <= S_IDLE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= c_resp_okay;
               end
            end

            // The request pulse itself is decoded combinationally from this
            // state and BUSY, so leaving REQ guarantees a single-cycle pulse.
            S_REQ: begin
               if (!BUSY) begin
                  r_state   <= S_WAIT_ACK;
                  r_ack_cnt <= 8'd0;
               end
            end

            // An acknowledge on the final allowed cycle still wins over the
            // timeout.
            S_WAIT_ACK: begin
               r_ack_cnt <= r_ack_cnt + 8'd1;
               if (sramahb_ack) begin
                  r_state     <= S_DONE;
                  r_hreadyout <= 1'b1;
                  r_hresp     <= c_resp_okay;
               end else if (w_timeout) begin
                  r_state     <= S_ERR1;
                  r_hreadyout <= 1'b0;
                  r_hresp     <= c_resp_error;
               end
            end

            S_ERR1: begin
               r_state     <= S_ERR2;
               r_hreadyout <= 1'b1;
               r_hresp     <= c_resp_error;
            end

            default: begin
               r_state     <= S_IDLE;
               r_hreadyout <= 1'b1;
               r_hresp     <= c_resp_okay;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output drive
   // ------------------------------------------------------------------------
   assign ahbsram_req   = (r_state == S_REQ) & ~BUSY;
   assign ahbsram_write = r_write;
   assign ahbsram_size  = r_size;
   assign ahbsram_addr  = r_addr;
   assign ahbsram_wdata = HWDATA;

   assign HREADYOUT     = r_hreadyout;
   assign HRESP         = r_hresp;
   assign HRDATA        = sramahb_rdata;

   // Inputs that carry no information for this slave.
   logic w_unused;
   assign w_unused = &{1'b0, HBURST, HTRANS[0], HADDR[31:MEM_AWIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_ahbl_sram_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_sram_slave_if
// Purpose  : Self-checking bench for ahbl_sram_slave_if. A behavioural SRAM
//            controller responds to requests; every transfer's outcome is
//            compared against a directed table and, for random traffic,
//            against a transfer-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahbl_sram_slave_if;

   localparam int AW = 19;
   localparam int TO = 15;

   logic        HCLK = 1'b0;
   logic        HRESETN;
   logic        HSEL, HWRITE, HREADYIN, HREADYOUT;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS, HRESP;
   logic [2:0]  HSIZE, HBURST;
   logic        ahbsram_req, ahbsram_write;
   logic [2:0]  ahbsram_size;
   logic [AW-1:0] ahbsram_addr;
   logic [31:0] ahbsram_wdata;
   logic        sramahb_ack, BUSY;
   logic [31:0] sramahb_rdata;

   always #5 HCLK = ~HCLK;

   ahbl_sram_slave_if #(.MEM_AWIDTH(AW), .ACK_TIMEOUT(TO), .SYNC_RESET(1'b0)) dut (
      .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
      .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write),
      .ahbsram_size(ahbsram_size), .ahbsram_addr(ahbsram_addr),
      .ahbsram_wdata(ahbsram_wdata), .sramahb_ack(sramahb_ack),
      .sramahb_rdata(sramahb_rdata), .BUSY(BUSY)
   );

   int errors = 0;
   int checks = 0;

   // ---------------- behavioural SRAM controller ----------------
   logic [31:0] stub_mem [int];
   logic        ack_en = 1'b1;
   logic        s_req = 1'b0, s_write = 1'b0;
   logic [AW-1:0] s_addr = '0;
   logic [31:0] s_wdata = '0;
   logic        st_pend = 1'b0, st_wr = 1'b0, st_ack_prev = 1'b0;
   int          st_word = 0;

   // Called just after each rising edge: acknowledge one cycle after a
   // request, present read data one cycle after the acknowledge.
   task automatic stub_update();
      if (st_ack_prev && st_pend) begin
         sramahb_rdata = (!st_wr && stub_mem.exists(st_word)) ? stub_mem[st_word] :
                         (!st_wr ? 32'h0 : $urandom);
         st_pend = 1'b0;
      end else begin
         sramahb_rdata = $urandom;
      end
      sramahb_ack = s_req & ack_en;
      if (s_req && ack_en) begin
         st_pend = 1'b1;
         st_wr   = s_write;
         st_word = int'(s_addr[AW-1:2]);
         if (s_write) stub_mem[st_word] = s_wdata;
      end
      st_ack_prev = sramahb_ack;
      s_req = 1'b0;
   endtask

   task automatic sample_stub();
      s_req   = ahbsram_req;
      s_write = ahbsram_write;
      s_addr  = ahbsram_addr;
      s_wdata = ahbsram_wdata;
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   typedef struct {
      int          waits;
      int          reqs;
      int          req_idx;
      logic [31:0] r_addr;
      logic [2:0]  r_size;
      logic        r_wr;
      logic [31:0] r_wdata;
      logic [1:0]  first_resp;
      logic [1:0]  final_resp;
      logic [31:0] final_rdata;
   } obs_t;

   // Drives one address phase in the current (HREADYOUT=1) cycle and follows
   // the transfer until the next HREADYOUT=1 cycle, which is left open so the
   // next address phase can be issued back-to-back.
   task automatic do_xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int busy_n, input bit hold,
                          input logic [1:0] trans, output obs_t o);
      bit done = 0;
      o = '{default: '0};
      ack_en   = !hold;
      HSEL     = 1'b1;
      HTRANS   = trans;
      HWRITE   = wr;
      HSIZE    = size;
      HADDR    = addr;
      HREADYIN = 1'b1;
      for (int c = 1; c <= 60 && !done; c++) begin
         @(posedge HCLK); #1;
         stub_update();
         HSEL     = 1'($urandom);
         HTRANS   = 2'($urandom);
         HREADYIN = 1'b0;
         HADDR    = $urandom;
         HWRITE   = 1'($urandom);
         HSIZE    = 3'($urandom);
         HWDATA   = wdata;
         BUSY     = (c <= busy_n);
         @(negedge HCLK);
         sample_stub();
         if (ahbsram_req) begin
            o.reqs++;
            if (o.reqs == 1) begin
               o.req_idx = c;
               o.r_addr  = 32'(ahbsram_addr);
               o.r_size  = ahbsram_size;
               o.r_wr    = ahbsram_write;
               o.r_wdata = ahbsram_wdata;
            end
         end
         if (c == 1) o.first_resp = HRESP;
         if (HREADYOUT) begin
            o.final_resp  = HRESP;
            o.final_rdata = HRDATA;
            done = 1;
         end else begin
            o.waits++;
         end
      end
      BUSY   = 1'b0;
      ack_en = 1'b1;
      if (hold) st_pend = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL xfer_hang: HREADYOUT still 0 after 60 cycles, required 1");
         finish_run();
      end
   endtask

   task automatic judge(input string tag, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata, input int busy_n,
                        input logic exp_req, input logic [1:0] exp_resp, input int exp_waits,
                        input logic [31:0] exp_rdata, input obs_t o);
      check({tag, " waits"}, 32'(o.waits), 32'(exp_waits));
      check({tag, " req_count"}, 32'(o.reqs), {31'd0, exp_req});
      check({tag, " final_resp"}, {30'd0, o.final_resp}, {30'd0, exp_resp});
      if (exp_req) begin
         check({tag, " req_cycle"}, 32'(o.req_idx), 32'(busy_n + 1));
         check({tag, " addr"}, o.r_addr, {13'd0, addr[AW-1:0]});
         check({tag, " size"}, {29'd0, o.r_size}, {29'd0, size});
         check({tag, " write"}, {31'd0, o.r_wr}, {31'd0, wr});
         if (wr) check({tag, " wdata"}, o.r_wdata, wdata);
         check({tag, " first_resp"}, {30'd0, o.first_resp}, 32'd0);
      end else begin
         check({tag, " first_resp"}, {30'd0, o.first_resp}, 32'd1);
      end
      if (!wr && exp_resp == 2'b00) check({tag, " rdata"}, o.final_rdata, exp_rdata);
   endtask

   // One cycle with no valid address phase for this slave, optionally with a
   // stray acknowledge from the controller.
   task automatic idle_cycle(input int kind, input bit stray);
      HSEL = 1'b1; HTRANS = 2'b00; HREADYIN = 1'b1;
      case (kind)
         0: begin HSEL = 1'b0; HTRANS = 2'b10; end
         1: HTRANS = 2'b00;
         2: HTRANS = 2'b01;
         default: begin HTRANS = 2'b10; HREADYIN = 1'b0; end
      endcase
      HSIZE = 3'($urandom); HADDR = $urandom; HWRITE = 1'($urandom);
      @(posedge HCLK); #1;
      stub_update();
      if (stray) sramahb_ack = 1'b1;
      @(negedge HCLK);
      sample_stub();
      check("idle ready", {31'd0, HREADYOUT}, 32'd1);
      check("idle resp", {30'd0, HRESP}, 32'd0);
      check("idle req", {31'd0, ahbsram_req}, 32'd0);
   endtask

   // ---------------- reference model (transfer level) ----------------
   logic [31:0] model_mem [int];

   function automatic bit legal_f(input logic [2:0] sz, input logic [31:0] a);
      return (sz == 3'd0) || (sz == 3'd1 && a[0] == 1'b0) || (sz == 3'd2 && a[1:0] == 2'b00);
   endfunction

   // ---------------- directed table ----------------
   typedef struct {
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          busy_n;
      bit          hold;
      int          gap;
      logic        exp_req;
      logic [1:0]  exp_resp;
      int          exp_waits;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl [12];

   initial begin
      obs_t o;
      HRESETN = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'd0; HBURST = 3'd0; HWDATA = '0; HREADYIN = 1'b1;
      sramahb_ack = 1'b0; sramahb_rdata = '0; BUSY = 1'b0;

      //          wr    size    addr          wdata        busy hold gap req resp waits rdata
      tbl[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 0, 0, 0, 1'b1, 2'b00, 2,      32'h0};
      tbl[1]  = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        0, 0, 1, 1'b1, 2'b00, 2,      32'hDEADBEEF};
      tbl[2]  = '{1'b0, 3'b001, 32'h0000_0011, 32'h0,        0, 0, 0, 1'b0, 2'b01, 1,      32'h0};
      tbl[3]  = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,        0, 0, 0, 1'b0, 2'b01, 1,      32'h0};
      tbl[4]  = '{1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 3, 0, 0, 1'b1, 2'b00, 5,     32'h0};
      tbl[5]  = '{1'b1, 3'b001, 32'h0000_0022, 32'h1234_5678, 0, 0, 2, 1'b1, 2'b00, 2,     32'h0};
      tbl[6]  = '{1'b0, 3'b000, 32'h0000_0021, 32'h0,        1, 0, 0, 1'b1, 2'b00, 3,      32'h1234_5678};
      tbl[7]  = '{1'b1, 3'b010, 32'h0000_0006, 32'h5555_AAAA, 0, 0, 0, 1'b0, 2'b01, 1,     32'h0};
      tbl[8]  = '{1'b0, 3'b010, 32'hFFF8_0010, 32'h0,        0, 0, 0, 1'b1, 2'b00, 2,      32'h0000_00A5};
      tbl[9]  = '{1'b0, 3'b010, 32'h0000_0040, 32'h0,        0, 1, 1, 1'b1, 2'b01, TO + 2, 32'h0};
      tbl[10] = '{1'b1, 3'b111, 32'h0000_0000, 32'h0,        0, 0, 0, 1'b0, 2'b01, 1,      32'h0};
      tbl[11] = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,        2, 0, 0, 1'b1, 2'b00, 4,      32'h0000_00A5};

      // ---- reset ----
      repeat (3) @(posedge HCLK);
      @(negedge HCLK);
      check("rst ready", {31'd0, HREADYOUT}, 32'd1);
      check("rst resp", {30'd0, HRESP}, 32'd0);
      check("rst req", {31'd0, ahbsram_req}, 32'd0);
      check("rst addr", {13'd0, ahbsram_addr}, 32'd0);
      check("rst size_write", {28'd0, ahbsram_size, ahbsram_write}, 32'd0);
      @(posedge HCLK); #1;
      HRESETN = 1'b1;
      @(negedge HCLK);
      check("post_rst ready", {31'd0, HREADYOUT}, 32'd1);
      check("post_rst req", {31'd0, ahbsram_req}, 32'd0);

      // ---- directed table ----
      for (int i = 0; i < 12; i++) begin
         do_xfer(tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata, tbl[i].busy_n,
                 tbl[i].hold, 2'b10, o);
         judge($sformatf("vec%0d", i), tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata,
               tbl[i].busy_n, tbl[i].exp_req, tbl[i].exp_resp, tbl[i].exp_waits,
               tbl[i].exp_rdata, o);
         for (int g = 0; g < tbl[i].gap; g++) idle_cycle(g, 1'b1);
      end

      // ---- randomized traffic against the reference model ----
      stub_mem.delete();
      model_mem.delete();
      for (int n = 0; n < 150; n++) begin
         logic        wr, hold, exp_req;
         logic [2:0]  size;
         logic [31:0] addr, wdata, exp_rdata;
         logic [1:0]  exp_resp;
         int          r, busy_n, exp_waits, word;
         wr     = 1'($urandom_range(0, 1));
         r      = $urandom_range(0, 9);
         size   = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
         addr   = {13'($urandom), 13'd0, 6'($urandom)};
         wdata  = $urandom;
         busy_n = $urandom_range(0, 3);
         hold   = ($urandom_range(0, 19) == 0);
         word   = int'(addr[AW-1:2]);

         exp_req   = legal_f(size, addr);
         exp_resp  = (!exp_req || hold) ? 2'b01 : 2'b00;
         exp_waits = !exp_req ? 1 : (hold ? busy_n + TO + 2 : busy_n + 2);
         exp_rdata = model_mem.exists(word) ? model_mem[word] : 32'h0;

         do_xfer(wr, size, addr, wdata, busy_n, hold, 2'($urandom_range(2, 3)), o);
         judge($sformatf("rnd%0d", n), wr, size, addr, wdata, busy_n, exp_req, exp_resp,
               exp_waits, exp_rdata, o);
         if (exp_req && !hold && wr) model_mem[word] = wdata;

         r = $urandom_range(0, 2);
         for (int g = 0; g < r; g++) idle_cycle($urandom_range(0, 3), 1'($urandom));
      end

      // ---- reset in the middle of an acknowledge wait ----
      ack_en = 1'b0;
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
      HADDR = 32'h30; HREADYIN = 1'b1; HWDATA = 32'hCAFE_F00D;
      for (int c = 0; c < 4; c++) begin
         @(posedge HCLK); #1;
         stub_update();
         HSEL = 1'b0; HTRANS = 2'b00;
      end
      @(negedge HCLK);
      check("midrst waiting", {31'd0, HREADYOUT}, 32'd0);
      #2;
      HRESETN = 1'b0;
      #1;
      check("midrst ready", {31'd0, HREADYOUT}, 32'd1);
      check("midrst resp", {30'd0, HRESP}, 32'd0);
      check("midrst req", {31'd0, ahbsram_req}, 32'd0);
      @(posedge HCLK); #1;
      HRESETN = 1'b1;
      ack_en = 1'b1;
      st_pend = 1'b0;
      s_req = 1'b0;
      @(negedge HCLK);
      sample_stub();
      check("after_rst ready", {31'd0, HREADYOUT}, 32'd1);
      do_xfer(1'b1, 3'b010, 32'h44, 32'h0BAD_F00D, 0, 1'b0, 2'b10, o);
      judge("after_rst_wr", 1'b1, 3'b010, 32'h44, 32'h0BAD_F00D, 0, 1'b1, 2'b00, 2, 32'h0, o);
      do_xfer(1'b0, 3'b010, 32'h44, 32'h0, 0, 1'b0, 2'b10, o);
      judge("after_rst_rd", 1'b0, 3'b010, 32'h44, 32'h0, 0, 1'b1, 2'b00, 2, 32'h0BAD_F00D, o);
      idle_cycle(1, 1'b0);

      finish_run();
   end

endmodule
`default_nettype wire
